// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: two-stage pipelined VGA test-pattern generator with delay-matched sync and per-frame mode/bar update
module vga_pattern_gen #(
  parameter int   COLOR_W   = 4,
  parameter int   COORD_W   = 10,
  parameter int   H_ACTIVE  = 640,
  parameter int   V_ACTIVE  = 480,
  parameter int   CHK_LOG2  = 5,
  parameter int   BAR_W     = 32,
  parameter int   BAR_STEP  = 4,
  parameter logic SYNC_IDLE = 1'b1,
  parameter int   FRAME_W   = 8
) (
  input  logic               clk25,
  input  logic               reset,
  input  logic [COORD_W-1:0] px_x,
  input  logic [COORD_W-1:0] px_y,
  input  logic               vidSel,
  input  logic               HS_in,
  input  logic               VS_in,
  input  logic [1:0]         mode,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b,
  output logic               HS,
  output logic               VS,
  output logic [FRAME_W-1:0] frame_cnt
);
  localparam logic [COORD_W:0]   H = (COORD_W+1)'(H_ACTIVE);
  localparam logic [COLOR_W-1:0] F = '1;
  logic [1:0]         mode_q, mode1;
  logic [COORD_W-1:0] bar_pos, bar1, x1, y1;
  logic               vid1, hs1, vs1, tick, hit;
  logic [COORD_W:0]   step_sum, bar_end, xe;
  logic [2:0]         k, quad, sel;
  assign tick     = vidSel && px_x == COORD_W'(H_ACTIVE - 1) && px_y == COORD_W'(V_ACTIVE - 1);
  assign step_sum = {1'b0, bar_pos} + (COORD_W+1)'(BAR_STEP);
  assign bar_end  = {1'b0, bar1} + (COORD_W+1)'(BAR_W);
  assign xe       = {1'b0, x1};
  assign hit      = (xe >= {1'b0, bar1} && xe < bar_end) || (bar_end > H && xe < bar_end - H);
  assign quad     = {x1 < COORD_W'(H_ACTIVE / 2) && y1 < COORD_W'(V_ACTIVE / 2),
                     y1 >= COORD_W'(V_ACTIVE / 2),
                     x1 >= COORD_W'(H_ACTIVE / 2)};
  always_comb begin
    k = '0;
    for (int i = 1; i < 8; i++) k = x1 >= COORD_W'(i * (H_ACTIVE / 8)) ? 3'(i) : k;
  end
  assign sel = mode1 == 2'd0 ? quad :
               mode1 == 2'd1 ? k :
               mode1 == 2'd2 ? {3{x1[CHK_LOG2] ^ y1[CHK_LOG2]}} : {3{hit}};
  always_ff @(posedge clk25) begin
    if (reset) begin
      mode_q    <= '0;
      bar_pos   <= '0;
      frame_cnt <= '0;
      {x1, y1, mode1, bar1} <= '0;
      vid1      <= 1'b0;
      hs1       <= SYNC_IDLE;
      vs1       <= SYNC_IDLE;
      r         <= '0;
      g         <= '0;
      b         <= '0;
      HS        <= SYNC_IDLE;
      VS        <= SYNC_IDLE;
    end else begin
      if (tick) begin
        mode_q    <= mode;
        frame_cnt <= frame_cnt + 1'b1;
        bar_pos   <= step_sum >= H ? COORD_W'(step_sum - H) : step_sum[COORD_W-1:0];
      end
      x1    <= px_x;
      y1    <= px_y;
      vid1  <= vidSel;
      hs1   <= HS_in;
      vs1   <= VS_in;
      mode1 <= mode_q;
      bar1  <= bar_pos;
      r     <= vid1 && sel[2] ? F : '0;
      g     <= vid1 && sel[1] ? F : '0;
      b     <= !vid1 ? '0 : sel[0] ? F : mode1 == 2'd3 ? F >> 1 : '0;
      HS    <= hs1;
      VS    <= vs1;
    end
  end
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: scoreboard bench for vga_pattern_gen with directed pixels and frame ticks
module tb_vga_pattern_gen;
  logic       clk25 = 1'b0, reset = 1'b1;
  logic [9:0] px_x = '0, px_y = '0;
  logic       vidSel = 1'b0, HS_in = 1'b1, VS_in = 1'b1;
  logic [1:0] mode = '0;
  logic [3:0] r, g, b;
  logic       HS, VS;
  logic [7:0] frame_cnt;
  typedef struct {
    int          due;
    bit          px;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    bit          fcc;
    logic [7:0]  fc;
    string       nm;
  } item_t;
  item_t q[$];
  int cyc = 0, errors = 0, checks = 0;
  bit done = 1'b0;
  vga_pattern_gen dut (
    .clk25(clk25), .reset(reset), .px_x(px_x), .px_y(px_y), .vidSel(vidSel),
    .HS_in(HS_in), .VS_in(VS_in), .mode(mode), .r(r), .g(g), .b(b),
    .HS(HS), .VS(VS), .frame_cnt(frame_cnt)
  );
  always #20 clk25 = ~clk25;
  always @(posedge clk25) cyc <= cyc + 1;
  task automatic step(input int x, input int y, input logic v, input logic h, input logic vv);
    @(posedge clk25);
    #1;
    px_x   = 10'(x);
    px_y   = 10'(y);
    vidSel = v;
    HS_in  = h;
    VS_in  = vv;
  endtask
  task automatic tick();
    step(639, 479, 1'b1, 1'b1, 1'b1);
  endtask
  task automatic epx(input string nm, input logic [11:0] rgb, input logic h, input logic vv, input int lat);
    item_t it;
    it.due = cyc + lat; it.px = 1'b1; it.rgb = rgb; it.hs = h; it.vs = vv;
    it.fcc = 1'b0; it.fc = '0; it.nm = nm;
    q.push_back(it);
  endtask
  task automatic efc(input string nm, input logic [7:0] fc, input int lat);
    item_t it;
    it.due = cyc + lat; it.px = 1'b0; it.rgb = '0; it.hs = 1'b1; it.vs = 1'b1;
    it.fcc = 1'b1; it.fc = fc; it.nm = nm;
    q.push_back(it);
  endtask
  task automatic cmp(input item_t it);
    checks++;
    if (it.px && {r, g, b, HS, VS} !== {it.rgb, it.hs, it.vs}) begin
      errors++;
      $display("FAIL %s: got rgb=%h hs=%b vs=%b, want rgb=%h hs=%b vs=%b",
               it.nm, {r, g, b}, HS, VS, it.rgb, it.hs, it.vs);
    end
    if (it.fcc && frame_cnt !== it.fc) begin
      errors++;
      $display("FAIL %s: got frame_cnt=%0d, want %0d", it.nm, frame_cnt, it.fc);
    end
  endtask
  initial begin
    forever begin
      @(negedge clk25);
      for (int i = 0; i < q.size();) begin
        if (q[i].due == cyc) begin
          cmp(q[i]);
          q.delete(i);
        end else i++;
      end
      if (done) begin
        foreach (q[i]) begin
          checks++;
          errors++;
          $display("FAIL %s: expectation never reached, due cycle %0d", q[i].nm, q[i].due);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end
  initial begin
    step(0, 0, 1'b0, 1'b1, 1'b1);
    step(0, 0, 1'b0, 1'b1, 1'b1);
    step(100, 100, 1'b1, 1'b1, 1'b1); reset = 1'b0;
    epx("rst_release", 12'h000, 1'b1, 1'b1, 1); efc("fc_reset", 8'd0, 1);
    epx("quad_tl", 12'hF00, 1'b1, 1'b1, 2);
    step(400, 300, 1'b1, 1'b1, 1'b1); epx("quad_br", 12'h0FF, 1'b1, 1'b1, 2);
    step(400, 300, 1'b1, 1'b0, 1'b1); epx("hs_pulse", 12'h0FF, 1'b0, 1'b1, 2);
    step(400, 300, 1'b1, 1'b1, 1'b0); epx("vs_pulse", 12'h0FF, 1'b1, 1'b0, 2);
    step(400, 300, 1'b1, 1'b1, 1'b1); epx("sync_back", 12'h0FF, 1'b1, 1'b1, 2);
    tick(); mode = 2'd1; epx("tick1_quad", 12'h0FF, 1'b1, 1'b1, 2); efc("fc_1", 8'd1, 1);
    step(80, 5, 1'b1, 1'b1, 1'b1); epx("bars_pre_rst", 12'h00F, 1'b1, 1'b1, 2);
    step(0, 0, 1'b0, 1'b1, 1'b1);
    repeat (3) begin
      step(100, 100, 1'b1, 1'b0, 1'b1); reset = 1'b1;
      epx("rst_idle", 12'h000, 1'b1, 1'b1, 1); efc("fc_rst", 8'd0, 1);
    end
    step(100, 100, 1'b1, 1'b1, 1'b1); reset = 1'b0; mode = 2'd2;
    epx("rst_release2", 12'h000, 1'b1, 1'b1, 1); epx("quad_after_rst", 12'hF00, 1'b1, 1'b1, 2);
    step(32, 0, 1'b1, 1'b1, 1'b1); epx("mode_not_latched", 12'hF00, 1'b1, 1'b1, 2);
    tick(); mode = 2'd1; epx("tick2_quad", 12'h0FF, 1'b1, 1'b1, 2); efc("fc_after_rst", 8'd1, 1);
    step(0, 0, 1'b1, 1'b1, 1'b1);   epx("bars_x0", 12'h000, 1'b1, 1'b1, 2);
    step(79, 0, 1'b1, 1'b1, 1'b1);  epx("bars_x79", 12'h000, 1'b1, 1'b1, 2);
    step(80, 0, 1'b1, 1'b1, 1'b1);  epx("bars_x80", 12'h00F, 1'b1, 1'b1, 2);
    step(320, 0, 1'b1, 1'b1, 1'b1); epx("bars_x320", 12'hF00, 1'b1, 1'b1, 2);
    step(559, 0, 1'b1, 1'b1, 1'b1); epx("bars_x559", 12'hFF0, 1'b1, 1'b1, 2);
    step(560, 0, 1'b1, 1'b1, 1'b1); epx("bars_x560", 12'hFFF, 1'b1, 1'b1, 2);
    step(639, 0, 1'b1, 1'b1, 1'b1); epx("bars_x639", 12'hFFF, 1'b1, 1'b1, 2);
    step(639, 0, 1'b0, 1'b1, 1'b1); epx("bars_blank", 12'h000, 1'b1, 1'b1, 2);
    step(0, 0, 1'b1, 1'b1, 1'b1); mode = 2'd2; epx("toggle_hold0", 12'h000, 1'b1, 1'b1, 2);
    step(100, 0, 1'b1, 1'b1, 1'b1); epx("toggle_hold", 12'h00F, 1'b1, 1'b1, 2);
    tick(); epx("tick3_bars", 12'hFFF, 1'b1, 1'b1, 2); efc("fc_2", 8'd2, 1);
    step(0, 0, 1'b1, 1'b1, 1'b1);   epx("chk_0_0", 12'h000, 1'b1, 1'b1, 2);
    step(32, 0, 1'b1, 1'b1, 1'b1);  epx("chk_32_0", 12'hFFF, 1'b1, 1'b1, 2);
    step(32, 32, 1'b1, 1'b1, 1'b1); epx("chk_32_32", 12'h000, 1'b1, 1'b1, 2);
    step(0, 32, 1'b1, 1'b1, 1'b1);  epx("chk_0_32", 12'hFFF, 1'b1, 1'b1, 2);
    step(31, 0, 1'b1, 1'b1, 1'b1);  epx("chk_31_0", 12'h000, 1'b1, 1'b1, 2);
    tick(); mode = 2'd3; epx("tick4_chk", 12'hFFF, 1'b1, 1'b1, 2); efc("fc_3", 8'd3, 1);
    step(11, 0, 1'b1, 1'b1, 1'b1); epx("mov12_x11", 12'h007, 1'b1, 1'b1, 2);
    step(12, 0, 1'b1, 1'b1, 1'b1); epx("mov12_x12", 12'hFFF, 1'b1, 1'b1, 2);
    step(43, 0, 1'b1, 1'b1, 1'b1); epx("mov12_x43", 12'hFFF, 1'b1, 1'b1, 2);
    step(44, 0, 1'b1, 1'b1, 1'b1); epx("mov12_x44", 12'h007, 1'b1, 1'b1, 2);
    step(44, 0, 1'b0, 1'b1, 1'b1); epx("mov_blank", 12'h000, 1'b1, 1'b1, 2);
    repeat (152) tick();
    step(619, 0, 1'b1, 1'b1, 1'b1); efc("fc_155", 8'd155, 0); epx("mov620_x619", 12'h007, 1'b1, 1'b1, 2);
    step(620, 0, 1'b1, 1'b1, 1'b1); epx("mov620_x620", 12'hFFF, 1'b1, 1'b1, 2);
    step(639, 0, 1'b1, 1'b1, 1'b1); epx("mov620_x639", 12'hFFF, 1'b1, 1'b1, 2);
    step(0, 0, 1'b1, 1'b1, 1'b1);   epx("mov620_x0", 12'hFFF, 1'b1, 1'b1, 2);
    step(11, 0, 1'b1, 1'b1, 1'b1);  epx("mov620_x11", 12'hFFF, 1'b1, 1'b1, 2);
    step(12, 0, 1'b1, 1'b1, 1'b1);  epx("mov620_x12", 12'h007, 1'b1, 1'b1, 2);
    repeat (5) tick();
    step(0, 0, 1'b1, 1'b1, 1'b1); efc("fc_160", 8'd160, 0); epx("mov0_x0", 12'hFFF, 1'b1, 1'b1, 2);
    step(31, 0, 1'b1, 1'b1, 1'b1);  epx("mov0_x31", 12'hFFF, 1'b1, 1'b1, 2);
    step(32, 0, 1'b1, 1'b1, 1'b1);  epx("mov0_x32", 12'h007, 1'b1, 1'b1, 2);
    step(639, 0, 1'b1, 1'b1, 1'b1); epx("mov0_x639", 12'h007, 1'b1, 1'b1, 2);
    repeat (96) tick();
    step(384, 0, 1'b1, 1'b1, 1'b1); efc("fc_wrap", 8'd0, 0); epx("mov384_x384", 12'hFFF, 1'b1, 1'b1, 2);
    step(383, 0, 1'b1, 1'b1, 1'b1); epx("mov384_x383", 12'h007, 1'b1, 1'b1, 2);
    step(415, 0, 1'b1, 1'b1, 1'b1); epx("mov384_x415", 12'hFFF, 1'b1, 1'b1, 2);
    step(416, 0, 1'b1, 1'b1, 1'b1); epx("mov384_x416", 12'h007, 1'b1, 1'b1, 2);
    repeat (4) step(0, 0, 1'b0, 1'b1, 1'b1);
    done = 1'b1;
  end
endmodule
